// File: rtl/coll_score_pkg.sv
// Shared definitions for the collision/score block.
//
// The `define constants below are the shared table geometry, direction
// encoding and seven-segment patterns. Segment patterns are active-low,
// bit0 = segment a ... bit6 = segment g.
//
// Package coll_score_pkg provides typed copies of the geometry, the
// player/side encoding and the seven-segment decoder.
//
// No ports (package only).

`ifndef COLL_SCORE_DEFS
`define COLL_SCORE_DEFS
`define LEFT          1'b1
`define TABLE_LEFT    16
`define TABLE_RIGHT   624
`define PADDLE_LEFT   24
`define PADDLE_RIGHT  608
`define PADDLE_WIDTH  8
`define PADDLE_HEIGHT 64
`define BALL_HSIZE    8
`define BALL_VSIZE    8
`define SEG_0     7'b1000000
`define SEG_1     7'b1111001
`define SEG_2     7'b0100100
`define SEG_3     7'b0110000
`define SEG_4     7'b0011001
`define SEG_5     7'b0010010
`define SEG_6     7'b0000010
`define SEG_7     7'b1111000
`define SEG_8     7'b0000000
`define SEG_9     7'b0010000
`define SEG_BLANK 7'b1111111
`define SEG_OTHER 7'b0001110
`endif

package coll_score_pkg;

  localparam logic DIR_LEFT      = `LEFT;
  localparam int   TABLE_LEFT    = `TABLE_LEFT;
  localparam int   TABLE_RIGHT   = `TABLE_RIGHT;
  localparam int   PADDLE_LEFT   = `PADDLE_LEFT;
  localparam int   PADDLE_RIGHT  = `PADDLE_RIGHT;
  localparam int   PADDLE_WIDTH  = `PADDLE_WIDTH;
  localparam int   PADDLE_HEIGHT = `PADDLE_HEIGHT;
  localparam int   BALL_HSIZE    = `BALL_HSIZE;
  localparam int   BALL_VSIZE    = `BALL_VSIZE;

  // Player identity, also the encoding of the winner output.
  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = `SEG_0;
      4'd1:    seg_decode = `SEG_1;
      4'd2:    seg_decode = `SEG_2;
      4'd3:    seg_decode = `SEG_3;
      4'd4:    seg_decode = `SEG_4;
      4'd5:    seg_decode = `SEG_5;
      4'd6:    seg_decode = `SEG_6;
      4'd7:    seg_decode = `SEG_7;
      4'd8:    seg_decode = `SEG_8;
      4'd9:    seg_decode = `SEG_9;
      default: seg_decode = `SEG_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/coll_score_bcd_counter.sv
// bcd_counter: DIGITS-digit BCD up-counter, wraps from all-9s to all-0s.
//
// Ports:
//   clk    in  1           system clock
//   rst    in  1           synchronous active-high reset
//   clr    in  1           synchronous clear (priority over inc)
//   inc    in  1           increment enable
//   digits out 4*DIGITS    BCD value, digit 0 (LSD) in bits [3:0]

module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   digits
);

  logic [4*DIGITS-1:0] digits_nx;
  logic                carry;

  // Ripple the increment through the digits; a 9 rolls to 0 and carries on.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable -- no latch.
    digits_nx = digits;
    carry     = inc;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (digits[i*4 +: 4] == 4'd9) begin
          digits_nx[i*4 +: 4] = 4'd0;
        end else begin
          digits_nx[i*4 +: 4] = digits[i*4 +: 4] + 4'd1;
          // NOTE: blocking assignment here so later loop iterations see the
          // updated carry within the same evaluation.
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all clocked state so every register samples
    // values from before the edge.
    if (rst || clr) begin
      digits <= '0;
    end else begin
      digits <= digits_nx;
    end
  end

endmodule

// File: rtl/coll_score.sv
// coll_score: ball collision detection, scoring, game-over and a
// multiplexed seven-segment score display.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   left_paddle_pos/right_paddle_pos [POS_W] paddle top positions
//   ball_h, ball_v [POS_W]         ball position
//   ball_dir                       `LEFT = moving left
//   ball_speed [4]                 pixels per step
//   score_clr                      start a new game
//   coll_paddle, coll_wall         registered collision levels
//   point_left, point_right        1-cycle pulse when that player scores
//   game_over, winner              end of game, winner 0 = left, 1 = right
//   seg [7]                        active-low segments, bit0 = a
//   an [2*DIGITS]                  active-low one-hot digit enable
//
// Optional feature: define COLL_SCORE_LZB_EN for leading-zero blanking of
// each player's score (the LSD is always shown).

module coll_score
  import coll_score_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int WIN_SCORE = 11,
  parameter int SCAN_DIV  = 50000,
  parameter int POS_W     = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [POS_W-1:0]      left_paddle_pos,
  input  logic [POS_W-1:0]      right_paddle_pos,
  input  logic [POS_W-1:0]      ball_h,
  input  logic [POS_W-1:0]      ball_v,
  input  logic                  ball_dir,
  input  logic [3:0]            ball_speed,
  input  logic                  score_clr,
  output logic                  coll_paddle,
  output logic                  coll_wall,
  output logic                  point_left,
  output logic                  point_right,
  output logic                  game_over,
  output logic                  winner,
  output logic [6:0]            seg,
  output logic [2*DIGITS-1:0]   an
);

  localparam int EW        = POS_W + 1;
  localparam int SLOTS     = 2 * DIGITS;
  localparam int SLOT_W    = $clog2(SLOTS);
  localparam int SCAN_W    = $clog2(SCAN_DIV);
  localparam int MAX_SCORE = 10**DIGITS - 1;
  localparam int CNT_W     = $clog2(MAX_SCORE + 1);

  // ---------------------------------------------------------------- collision
  // One extra bit of headroom so the right-hand sum never overflows.
  logic [EW-1:0] h_ext, spd_ext, v_ext, v_bot, lpad_ext, rpad_ext;
  logic [EW-1:0] left_edge, right_edge;
  logic          under, wall_l, wall_r, pad_l, pad_r, ovl_l, ovl_r;
  logic          wall_d, paddle_d;

  assign h_ext    = EW'(ball_h);
  assign spd_ext  = EW'(ball_speed);
  assign v_ext    = EW'(ball_v);
  assign lpad_ext = EW'(left_paddle_pos);
  assign rpad_ext = EW'(right_paddle_pos);

  // A ball closer to 0 than one step is past the left wall; the subtraction
  // would otherwise wrap to a huge value and miss the hit.
  assign under      = h_ext < spd_ext;
  assign left_edge  = h_ext - spd_ext;
  assign right_edge = h_ext + EW'(`BALL_HSIZE) + spd_ext;
  assign v_bot      = v_ext + EW'(`BALL_VSIZE);

  assign wall_l = under || (left_edge <= EW'(`TABLE_LEFT));
  assign wall_r = right_edge >= EW'(`TABLE_RIGHT);
  assign pad_l  = under || (left_edge <= EW'(`PADDLE_LEFT + `PADDLE_WIDTH));
  assign pad_r  = right_edge >= EW'(`PADDLE_RIGHT);
  assign ovl_l  = (v_ext <= lpad_ext + EW'(`PADDLE_HEIGHT)) && (v_bot >= lpad_ext);
  assign ovl_r  = (v_ext <= rpad_ext + EW'(`PADDLE_HEIGHT)) && (v_bot >= rpad_ext);

  // A wall hit masks any paddle hit.
  assign wall_d   = (ball_dir == `LEFT) ? wall_l : wall_r;
  assign paddle_d = !wall_d && ((ball_dir == `LEFT) ? (pad_l && ovl_l) : (pad_r && ovl_r));

  logic wall_right; // registered alongside coll_wall: 1 = right wall
  logic wall_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_wall   <= 1'b0;
      coll_paddle <= 1'b0;
      wall_right  <= 1'b0;
      wall_prev   <= 1'b0;
    end else begin
      coll_wall   <= wall_d;
      coll_paddle <= paddle_d;
      wall_right  <= (ball_dir != `LEFT);
      wall_prev   <= coll_wall;
    end
  end

  // ------------------------------------------------------------------ scoring
  logic                wall_rise, hit, inc_left, inc_right;
  logic [CNT_W-1:0]    left_cnt, right_cnt, left_cnt_nx, right_cnt_nx;
  logic [4*DIGITS-1:0] left_bcd, right_bcd;

  // A held wall contact scores once; score_clr discards a coincident edge.
  assign wall_rise = coll_wall && !wall_prev;
  assign hit       = wall_rise && !game_over && !score_clr;
  assign inc_left  = hit && wall_right;   // right wall: left player scores
  assign inc_right = hit && !wall_right;  // left wall: right player scores

  assign left_cnt_nx  = (left_cnt  == CNT_W'(MAX_SCORE)) ? '0 : left_cnt  + 1'b1;
  assign right_cnt_nx = (right_cnt == CNT_W'(MAX_SCORE)) ? '0 : right_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || score_clr) begin
      left_cnt    <= '0;
      right_cnt   <= '0;
      game_over   <= 1'b0;
      winner      <= SIDE_LEFT;
      point_left  <= 1'b0;
      point_right <= 1'b0;
    end else begin
      point_left  <= inc_left;
      point_right <= inc_right;
      if (inc_left) begin
        left_cnt <= left_cnt_nx;
        if (left_cnt_nx == CNT_W'(WIN_SCORE)) begin
          game_over <= 1'b1;
          winner    <= SIDE_LEFT;
        end
      end
      if (inc_right) begin
        right_cnt <= right_cnt_nx;
        if (right_cnt_nx == CNT_W'(WIN_SCORE)) begin
          game_over <= 1'b1;
          winner    <= SIDE_RIGHT;
        end
      end
    end
  end

  bcd_counter #(.DIGITS(DIGITS)) u_left_score (
    .clk    (clk),
    .rst    (rst),
    .clr    (score_clr),
    .inc    (inc_left),
    .digits (left_bcd)
  );

  bcd_counter #(.DIGITS(DIGITS)) u_right_score (
    .clk    (clk),
    .rst    (rst),
    .clr    (score_clr),
    .inc    (inc_right),
    .digits (right_bcd)
  );

  // ------------------------------------------------------------------ display
  logic [SCAN_W-1:0]   scan_cnt;
  logic [SLOT_W-1:0]   slot, slot_nx;
  logic                lit, tc;
  logic [4*DIGITS-1:0] sel_bcd;
  logic [3:0]          digit;
  logic                blank;
  logic [6:0]          seg_nx;
  logic [SLOTS-1:0]    an_nx;
  int                  slot_idx, digit_pos;

  assign tc = scan_cnt == SCAN_W'(SCAN_DIV - 1);

  // The first terminal count after reset lights slot 0 rather than
  // advancing, so the scan always starts at the left MSD.
  always_comb begin
    slot_nx = slot + 1'b1;
    if (!lit || slot == SLOT_W'(SLOTS - 1)) begin
      slot_nx = '0;
    end
  end

  // Decode the slot about to be shown, so seg/an change on the same edge
  // as the slot index.
  always_comb begin
    slot_idx  = int'(slot_nx);
    sel_bcd   = left_bcd;
    digit_pos = DIGITS - 1 - slot_idx;
    if (slot_idx >= DIGITS) begin
      sel_bcd   = right_bcd;
      digit_pos = SLOTS - 1 - slot_idx;
    end
    digit = sel_bcd[digit_pos*4 +: 4];
    blank = 1'b0;
`ifdef COLL_SCORE_LZB_EN
    // Blank unless this digit or any more significant one is non-zero.
    blank = (digit_pos != 0);
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= digit_pos && sel_bcd[k*4 +: 4] != 4'd0) begin
        blank = 1'b0;
      end
    end
`endif
    seg_nx = blank ? `SEG_BLANK : seg_decode(digit);
    an_nx  = ~(SLOTS'(1) << (SLOTS - 1 - slot_idx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      slot     <= '0;
      lit      <= 1'b0;
      seg      <= `SEG_BLANK;
      an       <= '1;
    end else if (tc) begin
      scan_cnt <= '0;
      slot     <= slot_nx;
      lit      <= 1'b1;
      seg      <= seg_nx;
      an       <= an_nx;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_coll_score.sv
// Testbench for coll_score. Two instances share the ball/paddle inputs:
// dut_a plays to 11, dut_b plays to 99 (reaches the BCD carries and the
// top-of-range game end). Each has its own score_clr. Expected point
// events are queued by a small game model as stimulus is issued and popped
// by per-instance monitors whenever a point pulse appears.

module tb_coll_score;
  import coll_score_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] left_paddle_pos, right_paddle_pos, ball_h, ball_v;
  logic        ball_dir;
  logic [3:0]  ball_speed;
  logic        clr_a, clr_b;

  logic       coll_paddle_a, coll_wall_a, point_left_a, point_right_a, game_over_a, winner_a;
  logic       coll_paddle_b, coll_wall_b, point_left_b, point_right_b, game_over_b, winner_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;

  always #5 clk = ~clk;

  coll_score #(.DIGITS(2), .WIN_SCORE(11), .SCAN_DIV(4), .POS_W(11)) dut_a (
    .clk(clk), .rst(rst),
    .left_paddle_pos(left_paddle_pos), .right_paddle_pos(right_paddle_pos),
    .ball_h(ball_h), .ball_v(ball_v), .ball_dir(ball_dir), .ball_speed(ball_speed),
    .score_clr(clr_a),
    .coll_paddle(coll_paddle_a), .coll_wall(coll_wall_a),
    .point_left(point_left_a), .point_right(point_right_a),
    .game_over(game_over_a), .winner(winner_a), .seg(seg_a), .an(an_a)
  );

  coll_score #(.DIGITS(2), .WIN_SCORE(99), .SCAN_DIV(4), .POS_W(11)) dut_b (
    .clk(clk), .rst(rst),
    .left_paddle_pos(left_paddle_pos), .right_paddle_pos(right_paddle_pos),
    .ball_h(ball_h), .ball_v(ball_v), .ball_dir(ball_dir), .ball_speed(ball_speed),
    .score_clr(clr_b),
    .coll_paddle(coll_paddle_b), .coll_wall(coll_wall_b),
    .point_left(point_left_b), .point_right(point_right_b),
    .game_over(game_over_b), .winner(winner_b), .seg(seg_b), .an(an_b)
  );

  typedef struct {
    bit         right_pt;  // 1 = point_right expected, 0 = point_left
    logic [7:0] l_bcd;
    logic [7:0] r_bcd;
    bit         go;
    bit         win;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  int   exp_l[2];
  int   exp_r[2];
  bit   exp_go[2];
  bit   exp_win[2];
  int   win_score[2] = '{11, 99};

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] PB = 7'b1111111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Game model: one wall contact applied to both instances.
  task automatic model_point(input bit right_wall, input bit [1:0] clr_mask);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (clr_mask[d]) begin
        exp_l[d] = 0; exp_r[d] = 0; exp_go[d] = 0; exp_win[d] = 0;
      end else if (!exp_go[d]) begin
        if (right_wall) exp_l[d]++;
        else            exp_r[d]++;
        if ((right_wall ? exp_l[d] : exp_r[d]) == win_score[d]) begin
          exp_go[d]  = 1'b1;
          exp_win[d] = !right_wall;
        end
        e.right_pt = !right_wall;
        e.l_bcd    = to_bcd(exp_l[d]);
        e.r_bcd    = to_bcd(exp_r[d]);
        e.go       = exp_go[d];
        e.win      = exp_win[d];
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
    end
  endtask

  task automatic mon(input int d, input logic pl, input logic pr,
                     input logic [7:0] lb, input logic [7:0] rb,
                     input logic go, input logic win);
    exp_t e;
    int   n;
    n = (d == 0) ? q_a.size() : q_b.size();
    if (n == 0) begin
      check($sformatf("dut%0d_unexpected_point", d), {pl, pr}, 2'b00);
    end else begin
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      check($sformatf("dut%0d_point_side", d), {pl, pr}, e.right_pt ? 2'b01 : 2'b10);
      check($sformatf("dut%0d_left_score", d), lb, e.l_bcd);
      check($sformatf("dut%0d_right_score", d), rb, e.r_bcd);
      check($sformatf("dut%0d_game_over", d), go, e.go);
      if (e.go) check($sformatf("dut%0d_winner", d), win, e.win);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (point_left_a || point_right_a))
      mon(0, point_left_a, point_right_a, dut_a.left_bcd, dut_a.right_bcd, game_over_a, winner_a);
    if (!rst && (point_left_b || point_right_b))
      mon(1, point_left_b, point_right_b, dut_b.left_bcd, dut_b.right_bcd, game_over_b, winner_b);
  end

  task automatic go_center();
    ball_dir   = DIR_LEFT;
    ball_h     = 11'd300;
    ball_v     = 11'd200;
    ball_speed = 4'd3;
  endtask

  // One wall contact held 10 cycles, then back to mid-table.
  task automatic wall_hit(input bit right_wall, input logic [10:0] h,
                          input logic [3:0] spd, input bit [1:0] clr_mask);
    @(posedge clk); #1;
    ball_dir   = right_wall ? ~DIR_LEFT : DIR_LEFT;
    ball_h     = h;
    ball_speed = spd;
    model_point(right_wall, clr_mask);
    @(negedge clk);
    check("wall_before_edge", coll_wall_a, 1'b0);
    @(posedge clk); #1;
    clr_a = clr_mask[0];
    clr_b = clr_mask[1];
    @(negedge clk);
    check("wall_after_1clk", coll_wall_a, 1'b1);
    check("paddle_masked_by_wall", coll_paddle_a, 1'b0);
    @(posedge clk); #1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    repeat (8) @(posedge clk);
    #1 go_center();
    repeat (3) @(posedge clk);
  endtask

  task automatic left_hit();
    wall_hit(1'b0, 11'(TABLE_LEFT + 2), 4'd3, 2'b00);
  endtask

  task automatic right_hit();
    wall_hit(1'b1, 11'(TABLE_RIGHT - BALL_HSIZE - 1), 4'd3, 2'b00);
  endtask

  task automatic paddle_vec(input string name, input logic dir, input logic [10:0] h,
                            input logic [3:0] spd, input logic [10:0] v, input logic req);
    @(posedge clk); #1;
    ball_dir = dir; ball_h = h; ball_speed = spd; ball_v = v;
    @(posedge clk);
    @(negedge clk);
    check(name, coll_paddle_a, req);
    check({name, "_wall"}, coll_wall_a, 1'b0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    left_paddle_pos = 11'd200; right_paddle_pos = 11'd200;
    go_center();
    for (int d = 0; d < 2; d++) begin
      exp_l[d] = 0; exp_r[d] = 0; exp_go[d] = 0; exp_win[d] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_coll_wall", coll_wall_a, 1'b0);
    check("rst_coll_paddle", coll_paddle_a, 1'b0);
    check("rst_points", {point_left_a, point_right_a}, 2'b00);
    check("rst_game_over", game_over_a, 1'b0);
    check("rst_winner", winner_a, 1'b0);
    check("rst_seg", seg_a, PB);
    check("rst_an", an_a, 4'hF);

    // First lit slot is slot 0, SCAN_DIV cycles after release
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scan_dark_before_tc", an_a, 4'hF);
    @(posedge clk);
    @(negedge clk);
    check("scan_first_slot0_an", an_a, 4'b0111);
`ifdef COLL_SCORE_LZB_EN
    check("scan_first_slot0_seg", seg_a, PB);
`else
    check("scan_first_slot0_seg", seg_a, P0);
`endif

    // Left wall hit: right player scores once
    left_hit();
    check("left_wall_right_score", dut_a.right_bcd, 8'h01);

    // Left paddle edge sweep
    for (int v = 191; v <= 265; v++)
      paddle_vec($sformatf("lpad_v%0d", v), DIR_LEFT, 11'(PADDLE_LEFT + PADDLE_WIDTH + 1),
                 4'd2, 11'(v), (v >= 192 && v <= 264));
    // Right paddle: exact edge reach, miss vertically, one pixel short
    paddle_vec("rpad_hit", ~DIR_LEFT, 11'(PADDLE_RIGHT - BALL_HSIZE - 2), 4'd2, 11'd200, 1'b1);
    paddle_vec("rpad_below", ~DIR_LEFT, 11'(PADDLE_RIGHT - BALL_HSIZE - 2), 4'd2, 11'd265, 1'b0);
    paddle_vec("rpad_short", ~DIR_LEFT, 11'(PADDLE_RIGHT - BALL_HSIZE - 2), 4'd1, 11'd200, 1'b0);
    @(posedge clk); #1 go_center();
    repeat (3) @(posedge clk);

    // Win at 11 for dut_a, 12th hit ignored
    for (int i = 0; i < 12; i++) right_hit();
    @(negedge clk);
    check("win_left_score", dut_a.left_bcd, 8'h11);
    check("win_game_over", game_over_a, 1'b1);
    check("win_winner", winner_a, 1'b0);

    // score_clr coinciding with a wall rising edge
    wall_hit(1'b0, 11'(TABLE_LEFT + 2), 4'd3, 2'b11);
    @(negedge clk);
    check("clr_a_left", dut_a.left_bcd, 8'h00);
    check("clr_a_right", dut_a.right_bcd, 8'h00);
    check("clr_a_game_over", game_over_a, 1'b0);
    check("clr_b_left", dut_b.left_bcd, 8'h00);
    check("clr_b_right", dut_b.right_bcd, 8'h00);

    // Build left=07 right=12 on dut_b; one hit uses ball_h < ball_speed
    for (int i = 0; i < 11; i++) left_hit();
    wall_hit(1'b0, 11'd1, 4'd5, 2'b00);
    for (int i = 0; i < 7; i++) right_hit();
    check("a_right_win_score", dut_a.right_bcd, 8'h11);
    check("a_right_winner", winner_a, 1'b1);

    // Display scan on dut_b
    n = 0;
    @(negedge clk);
    while (an_b !== 4'b0111 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scan_an_0", an_b, 4'b0111);
`ifdef COLL_SCORE_LZB_EN
    check("scan_seg_0", seg_b, PB);
`else
    check("scan_seg_0", seg_b, P0);
`endif
    repeat (4) @(negedge clk);
    check("scan_an_1", an_b, 4'b1011);
    check("scan_seg_1", seg_b, P7);
    repeat (4) @(negedge clk);
    check("scan_an_2", an_b, 4'b1101);
    check("scan_seg_2", seg_b, P1);
    repeat (4) @(negedge clk);
    check("scan_an_3", an_b, 4'b1110);
    check("scan_seg_3", seg_b, P2);

    // dut_b to 99 then one more
    for (int i = 0; i < 92; i++) right_hit();
    @(negedge clk);
    check("wrap_left_99", dut_b.left_bcd, 8'h99);
    check("wrap_game_over", game_over_b, 1'b1);
    check("wrap_winner", winner_b, 1'b0);
    right_hit();
    @(negedge clk);
    check("wrap_left_hold", dut_b.left_bcd, 8'h99);

    check("a_points_outstanding", q_a.size(), 0);
    check("b_points_outstanding", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coll_score.md
COLL_SCORE -- requirements
Module: coll_score

Interface
REQ-001 SHALL have parameter DIGITS, default 2: BCD digits per player score.
REQ-002 SHALL have parameter WIN_SCORE, default 11: binary point total that ends the game; legal range 1 to 10^DIGITS-1.
REQ-003 SHALL have parameter SCAN_DIV, default 50000: clk cycles per display digit slot; minimum 2.
REQ-004 SHALL have parameter POS_W, default 11: width of all position inputs.
REQ-005 SHALL have ports clk in 1 (system clock); rst in 1 (synchronous, active-high reset).
REQ-006 SHALL have ports left_paddle_pos in POS_W; right_paddle_pos in POS_W; ball_h in POS_W; ball_v in POS_W; ball_dir in 1 (`LEFT` = moving left); ball_speed in 4 (pixels per step).
REQ-007 SHALL have port score_clr in 1: start a new game.
REQ-008 SHALL have ports coll_paddle out 1 (level); coll_wall out 1 (level); point_left out 1 (1-cycle pulse: left player scored); point_right out 1 (1-cycle pulse: right player scored).
REQ-009 SHALL have ports game_over out 1; winner out 1 (0 = left, 1 = right, valid while game_over).
REQ-010 SHALL have ports seg out 7 (active-low segments a..g, bit0 = a); an out 2*DIGITS (active-low one-hot digit enable).

Function
REQ-011 SHALL register coll_wall and coll_paddle one clk after inputs are sampled. Registered condition when ball_dir==`LEFT`: wall if ball_h-ball_speed <= `TABLE_LEFT`. Otherwise registered condition: wall if ball_h+`BALL_HSIZE`+ball_speed >= `TABLE_RIGHT`.
REQ-012 SHALL assert coll_paddle only when coll_wall is not asserted. Condition: predicted edge crosses `PADDLE_LEFT`+`PADDLE_WIDTH` (left) or `PADDLE_RIGHT` (right), and ball_v <= pos+`PADDLE_HEIGHT` and ball_v+`BALL_VSIZE` >= pos (inclusive overlap).
REQ-013 SHALL evaluate all arithmetic at POS_W+1 bits. When ball_h < ball_speed, the left prediction SHALL be treated as <= `TABLE_LEFT` (no wrap).
REQ-014 SHALL score on the 0->1 edge of registered coll_wall only, detected within the clk domain. A held wall hit SHALL score once.
REQ-015 SHALL credit a left-wall hit to the right player and a right-wall hit to the left player. The matching point_* SHALL pulse on the cycle the score updates.
REQ-016 SHALL keep each score as DIGITS BCD digits plus a binary shadow count. The score SHALL wrap from all-9s to all-0s.
REQ-017 SHALL set game_over and winner on the cycle a shadow count reaches WIN_SCORE. While game_over: no score changes and no point pulses; collision outputs keep running.
REQ-018 SHALL, on score_clr, clear both scores, game_over, and winner next cycle. score_clr SHALL take priority over a simultaneous scoring edge, which is discarded.
REQ-019 SHALL run a scan counter 0..SCAN_DIV-1 and advance the slot index 0..2*DIGITS-1 (wrapping) at terminal count.
REQ-020 SHALL order the slots as follows. Slot 0 = left MSD on an[2*DIGITS-1]. The left player's digits occupy the upper anodes MSD to LSD, then the right player's digits.
REQ-021 SHALL update seg and an on the same clk edge as the slot index, with no extra slot of lag. Decode: 0-9 standard patterns; any other code 7'b0001110.
REQ-022 SHALL show score changes within one scan period.

Reset
REQ-023 SHALL, on rst, set coll_paddle=0, coll_wall=0, point_*=0, game_over=0, winner=0, scores=0, scan counter=0, slot=0, seg=7'b1111111, an=all ones.
REQ-024 SHALL abandon any display slot in progress when reset is asserted mid-scan. The first lit slot after reset release SHALL be slot 0, after SCAN_DIV cycles.
REQ-025 SHALL give rst priority over score_clr and all scoring.

Configuration
REQ-026 SHALL support macro COLL_SCORE_LZB_EN, which enables leading-zero blanking.
REQ-027 SHALL, with COLL_SCORE_LZB_EN defined, blank each player's leading zero digits (seg=7'b1111111, anode still driven). The LSD SHALL always be shown.
REQ-028 SHALL, without COLL_SCORE_LZB_EN, show all digits, zeros included.

Structure
REQ-029 SHALL take `LEFT`, `TABLE_LEFT`, `TABLE_RIGHT`, `PADDLE_LEFT`, `PADDLE_RIGHT`, `PADDLE_WIDTH`, `PADDLE_HEIGHT`, `BALL_HSIZE`, `BALL_VSIZE` and the seven-segment pattern constants from the shared defs include.
REQ-030 SHALL use one sub-module, bcd_counter: parameter DIGITS, synchronous clear, increment enable, wrap at all-9s. It SHALL be instantiated once per player.

Verification
REQ-031 SHALL test left wall hit. Stimulus: ball_dir=`LEFT`, ball_h=`TABLE_LEFT`+2, ball_speed=3, held 10 cycles. Required: coll_wall=1 after 1 cycle, one point_right pulse, right score 01, coll_paddle=0.
REQ-032 SHALL test left paddle edges. Stimulus: ball_dir=`LEFT`, ball_h=`PADDLE_LEFT`+`PADDLE_WIDTH`+1, speed 2, left_paddle_pos=200, ball_v swept 200-`BALL_VSIZE`-1 .. 200+`PADDLE_HEIGHT`+1. Required: coll_paddle=1 exactly from ball_v=200-`BALL_VSIZE` to 200+`PADDLE_HEIGHT` inclusive.
REQ-033 SHALL test the win condition. Stimulus: 11 separated right-wall hits, WIN_SCORE=11. Required: left score 11, game_over=1, winner=0. A 12th hit gives no pulse and score stays 11.
REQ-034 SHALL test BCD wrap. Stimulus: WIN_SCORE=99 unreachable override (set 99, DIGITS=2), 99 hits then 1 more with game_over checked. Required: 09->10 BCD carry correct and game_over at 99.
REQ-035 SHALL test score_clr coinciding with a wall rising edge. Required: scores 00, no point pulse, game_over=0.
REQ-036 SHALL test the display scan. Stimulus: SCAN_DIV=4, left=07, right=12. Required: an steps 0111,1011,1101,1110 every 4 cycles with seg 0 (or blank under COLL_SCORE_LZB_EN), 7, 1, 2.
